// File: rtl/niosprocessorlab_onchip_mem_bridge_pkg.sv
// Shared defaults for the on-chip RAM bridge and a helper that sizes
// occupancy counters so they can hold the full depth value.
package onchip_bridge_pkg;
   localparam int ADDR_W_DEF    = 10;
   localparam int DATA_W_DEF    = 32;
   localparam int RSP_DEPTH_DEF = 4;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/niosprocessorlab_onchip_mem_bridge_if.sv
// Bus bundles for the bridge: the upstream Avalon-MM request/response side
// and the downstream single-port RAM side.
interface onchip_avmm_if
   import onchip_bridge_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic [ADDR_W-1:0]   s_address;
   logic [DATA_W/8-1:0] s_byteenable;
   logic                s_read;
   logic                s_write;
   logic [DATA_W-1:0]   s_writedata;
   logic                s_waitrequest;
   logic [DATA_W-1:0]   s_readdata;
   logic                s_readdatavalid;
   logic                s_rsp_ready;

   modport master (
      output s_address, s_byteenable, s_read, s_write, s_writedata, s_rsp_ready,
      input  s_waitrequest, s_readdata, s_readdatavalid
   );
   modport slave (
      input  s_address, s_byteenable, s_read, s_write, s_writedata, s_rsp_ready,
      output s_waitrequest, s_readdata, s_readdatavalid
   );
endinterface

interface onchip_ram_if
   import onchip_bridge_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic [ADDR_W-1:0]   m_address;
   logic [DATA_W/8-1:0] m_byteenable;
   logic                m_chipselect;
   logic                m_write;
   logic [DATA_W-1:0]   m_writedata;
   logic                m_clken;
   logic [DATA_W-1:0]   m_readdata;

   modport master (
      output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      input  m_readdata
   );
   modport slave (
      input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      output m_readdata
   );
endinterface

// File: rtl/niosprocessorlab_onchip_mem_bridge_rsp_fifo.sv
// In-order registered response FIFO; simultaneous push and pop are both
// honoured. Head data reads as zero whenever the FIFO is empty.
module onchip_rsp_fifo
   import onchip_bridge_pkg::*;
#(
   parameter int DEPTH = RSP_DEPTH_DEF,
   parameter int WIDTH = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [cnt_w(DEPTH)-1:0]  count
);
   localparam int CNT_W = cnt_w(DEPTH);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   assign valid  = (count_q != '0);
   assign do_pop = pop & valid;
   assign dout   = valid ? mem_q[rd_ptr_q] : '0;
   assign count  = count_q;

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         assert (!(push && !do_pop && count_q == CNT_W'(DEPTH)))
            else $error("onchip_rsp_fifo overflow");
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/niosprocessorlab_onchip_mem_bridge.sv
// Request/response stage in front of the 1-cycle on-chip RAM: pass-through
// requests, credit-limited reads, and a buffered response channel.
module niosprocessorlab_onchip_mem_bridge
   import onchip_bridge_pkg::*;
#(
   parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   onchip_avmm_if.slave  s,
   onchip_ram_if.master  m,
   output logic          err_both
);
   localparam int CNT_W  = cnt_w(RSP_DEPTH);
   localparam int DATA_W = $bits(s.s_readdata);

   logic             rd_pend_q, rd_pend_d;
   logic             err_q, err_d;
   logic             clken_q, clken_d;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] outstanding;
   logic             rsp_valid;
   logic             pop;
   logic             rd_only;
   logic             rd_acc;

   assign m.m_address    = s.s_address;
   assign m.m_writedata  = s.s_writedata;
   assign m.m_byteenable = s.s_byteenable;
   assign m.m_clken      = clken_q;

   // A read counts against credits from acceptance until its FIFO entry pops.
   assign outstanding     = fifo_count + CNT_W'(rd_pend_q);
   assign pop             = rsp_valid & s.s_rsp_ready;
   assign rd_only         = s.s_read & ~s.s_write;
   assign s.s_waitrequest = rd_only & (outstanding == CNT_W'(RSP_DEPTH)) & ~pop;
   assign rd_acc          = rd_only & ~s.s_waitrequest;
   assign m.m_chipselect  = s.s_write | rd_acc;
   assign m.m_write       = s.s_write;
   assign s.s_readdatavalid = rsp_valid;
   assign err_both        = err_q;

   always_comb begin
      rd_pend_d = rd_acc;
      err_d     = err_q | (s.s_read & s.s_write);
      clken_d   = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend_q <= 1'b0;
         err_q     <= 1'b0;
         clken_q   <= 1'b0;
      end else begin
         rd_pend_q <= rd_pend_d;
         err_q     <= err_d;
         clken_q   <= clken_d;
      end
   end

   onchip_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
   ) u_rsp_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rd_pend_q),
      .din     (m.m_readdata),
      .pop     (pop),
      .dout    (s.s_readdata),
      .valid   (rsp_valid),
      .count   (fifo_count)
   );
endmodule
